pipelined_fetch_unit: RTL and testbench

//  Instruction-fetch stage of the pipelined MIPS CPU: the requesting side of the

---
 rtl/pipelined_fetch_unit_if.sv | 43 ++++
 rtl/pipelined_fetch_unit.sv | 73 +++++++
 tb/tb_pipelined_fetch_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pipelined_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, hazard/redirect
// controls from decode, and the IF/ID register outputs.
interface pipelined_fetch_unit_if;
    logic [31:0] ImemAddr;
    logic [31:0] ImemInst;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic [31:0] IfIdInst;
    logic [31:0] IfIdPcPlus4;
    logic        IfIdValid;
    logic        FetchFault;

    modport master (
        output ImemAddr,
        input  ImemInst,
        input  Stall,
        input  BranchTaken,
        input  BranchTarget,
        input  Jump,
        input  JumpTarget,
        output IfIdInst,
        output IfIdPcPlus4,
        output IfIdValid,
        output FetchFault
    );

    modport slave (
        input  ImemAddr,
        output ImemInst,
        output Stall,
        output BranchTaken,
        output BranchTarget,
        output Jump,
        output JumpTarget,
        input  IfIdInst,
        input  IfIdPcPlus4,
        input  IfIdValid,
        input  FetchFault
    );
endinterface

// File: rtl/pipelined_fetch_unit.sv
// Instruction-fetch stage: PC register, combinational ROM addressing and the
// IF/ID pipeline register with stall, branch/jump redirect and fault tracking.
module pipelined_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 32,
    parameter logic [31:0] NOP_INST  = 32'h0000_0000
) (
    input logic                    Clk,
    input logic                    Rst,
    pipelined_fetch_unit_if.master bus
);

    localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) << 2;

    logic [31:0] pc_q, pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic [31:0] if_pc4_q, if_pc4_d;
    logic        if_valid_q, if_valid_d;
    logic        fault_q, fault_d;

    logic [31:0] pc_plus4;
    logic        pc_bad;

    assign pc_plus4 = pc_q + 32'd4;
    assign pc_bad   = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} >= PC_LIMIT);

    always_comb begin
        pc_d       = pc_q;
        if_inst_d  = if_inst_q;
        if_pc4_d   = if_pc4_q;
        if_valid_d = if_valid_q;
        fault_d    = fault_q;

        // Redirects outrank Stall: the stalled ID instruction is the redirecting one.
        if (bus.BranchTaken || bus.Jump) begin
            pc_d       = bus.BranchTaken ? bus.BranchTarget : bus.JumpTarget;
            if_inst_d  = NOP_INST;
            if_pc4_d   = '0;
            if_valid_d = 1'b0;
        end else if (!bus.Stall) begin
            pc_d       = pc_plus4;
            if_inst_d  = bus.ImemInst;
            if_pc4_d   = pc_plus4;
            if_valid_d = !pc_bad;
            if (pc_bad) begin
                fault_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pc_q       <= RESET_PC;
            if_inst_q  <= NOP_INST;
            if_pc4_q   <= '0;
            if_valid_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            if_inst_q  <= if_inst_d;
            if_pc4_q   <= if_pc4_d;
            if_valid_q <= if_valid_d;
            fault_q    <= fault_d;
        end
    end

    assign bus.ImemAddr    = pc_q;
    assign bus.IfIdInst    = if_inst_q;
    assign bus.IfIdPcPlus4 = if_pc4_q;
    assign bus.IfIdValid   = if_valid_q;
    assign bus.FetchFault  = fault_q;

endmodule

// File: tb/tb_pipelined_fetch_unit.sv
// Directed-vector bench for pipelined_fetch_unit with a small combinational ROM.
module tb_pipelined_fetch_unit;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    pipelined_fetch_unit_if bus ();

    pipelined_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .MEM_WORDS(32),
        .NOP_INST (32'h0000_0000)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    always #5 Clk = ~Clk;

    // ROM: word i = 0x2000_0000 | i, except word 1; out-of-range reads return DEADBEEF.
    function automatic logic [31:0] rom(input logic [31:0] a);
        if (a >= 32'd128) return 32'hDEAD_BEEF;
        if (a[6:2] == 5'd1) return 32'h2021_000a;
        return 32'h2000_0000 | {27'd0, a[6:2]};
    endfunction

    assign bus.ImemInst = rom(bus.ImemAddr);

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        bus.Stall = 1'b0;
        bus.BranchTaken = 1'b0;
        bus.Jump = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Stall = 1'b0;
        bus.BranchTaken = 1'b0;
        bus.BranchTarget = '0;
        bus.Jump = 1'b0;
        bus.JumpTarget = '0;
        step();
        step();
        check_val("rst_addr", bus.ImemAddr, 32'd0);
        check_val("rst_inst", bus.IfIdInst, 32'd0);
        check_val("rst_pc4", bus.IfIdPcPlus4, 32'd0);
        check_val("rst_valid", {31'd0, bus.IfIdValid}, 32'd0);
        check_val("rst_fault", {31'd0, bus.FetchFault}, 32'd0);
        Rst = 1'b0;

        // T2 sequential
        step();
        check_val("seq1_inst", bus.IfIdInst, 32'h2000_0000);
        step();
        check_val("seq2_inst", bus.IfIdInst, 32'h2021_000a);
        check_val("seq2_pc4", bus.IfIdPcPlus4, 32'd8);
        step();
        check_val("seq3_addr", bus.ImemAddr, 32'd12);
        check_val("seq3_inst", bus.IfIdInst, 32'h2000_0002);
        check_val("seq3_pc4", bus.IfIdPcPlus4, 32'd12);
        check_val("seq3_valid", {31'd0, bus.IfIdValid}, 32'd1);
        step();
        check_val("pre_stall_addr", bus.ImemAddr, 32'd16);

        // T3 stall for two cycles at PC=16
        bus.Stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_val("stall_addr", bus.ImemAddr, 32'd16);
            check_val("stall_inst", bus.IfIdInst, 32'h2000_0003);
            check_val("stall_pc4", bus.IfIdPcPlus4, 32'd16);
            check_val("stall_valid", {31'd0, bus.IfIdValid}, 32'd1);
        end
        bus.Stall = 1'b0;
        step();
        check_val("unstall_addr", bus.ImemAddr, 32'd20);
        check_val("unstall_inst", bus.IfIdInst, 32'h2000_0004);

        // T4 branch overrides stall
        bus.BranchTaken = 1'b1;
        bus.BranchTarget = 32'h3C;
        bus.Stall = 1'b1;
        step();
        idle();
        check_val("br_addr", bus.ImemAddr, 32'h3C);
        check_val("br_valid", {31'd0, bus.IfIdValid}, 32'd0);
        check_val("br_inst", bus.IfIdInst, 32'd0);
        check_val("br_pc4", bus.IfIdPcPlus4, 32'd0);
        step();
        check_val("br_next_inst", bus.IfIdInst, 32'h2000_000f);
        check_val("br_next_pc4", bus.IfIdPcPlus4, 32'h40);
        check_val("br_next_valid", {31'd0, bus.IfIdValid}, 32'd1);

        // T5 branch beats jump
        bus.Jump = 1'b1;
        bus.JumpTarget = 32'd4;
        bus.BranchTaken = 1'b1;
        bus.BranchTarget = 32'h30;
        step();
        idle();
        check_val("prio_addr", bus.ImemAddr, 32'h30);
        check_val("prio_valid", {31'd0, bus.IfIdValid}, 32'd0);

        // Jump alone
        bus.Jump = 1'b1;
        bus.JumpTarget = 32'h8;
        step();
        idle();
        check_val("jmp_addr", bus.ImemAddr, 32'h8);
        step();
        check_val("jmp_next_inst", bus.IfIdInst, 32'h2000_0002);

        // T1 asynchronous reset mid-cycle
        #2;
        Rst = 1'b1;
        #1;
        check_val("arst_addr", bus.ImemAddr, 32'd0);
        check_val("arst_valid", {31'd0, bus.IfIdValid}, 32'd0);
        check_val("arst_inst", bus.IfIdInst, 32'd0);
        step();
        check_val("arst_hold_addr", bus.ImemAddr, 32'd0);
        Rst = 1'b0;
        step();
        check_val("arst_restart_addr", bus.ImemAddr, 32'd4);

        // T6 out-of-range fault
        bus.Jump = 1'b1;
        bus.JumpTarget = 32'h80;
        step();
        idle();
        check_val("oor_redirect_fault", {31'd0, bus.FetchFault}, 32'd0);
        step();
        check_val("oor_fault", {31'd0, bus.FetchFault}, 32'd1);
        check_val("oor_valid", {31'd0, bus.IfIdValid}, 32'd0);
        check_val("oor_inst", bus.IfIdInst, 32'hDEAD_BEEF);
        check_val("oor_pc4", bus.IfIdPcPlus4, 32'h84);
        bus.BranchTaken = 1'b1;
        bus.BranchTarget = 32'h0;
        step();
        idle();
        step();
        check_val("fault_sticky", {31'd0, bus.FetchFault}, 32'd1);
        check_val("fault_sticky_valid", {31'd0, bus.IfIdValid}, 32'd1);

        // PC wrap at 0xFFFF_FFFC
        bus.BranchTaken = 1'b1;
        bus.BranchTarget = 32'hFFFF_FFFC;
        step();
        idle();
        step();
        check_val("wrap_addr", bus.ImemAddr, 32'd0);
        check_val("wrap_pc4", bus.IfIdPcPlus4, 32'd0);

        Rst = 1'b1;
        step();
        check_val("fault_clr", {31'd0, bus.FetchFault}, 32'd0);
        Rst = 1'b0;

        // Misaligned redirect target
        bus.Jump = 1'b1;
        bus.JumpTarget = 32'h2;
        step();
        idle();
        check_val("mis_redirect_fault", {31'd0, bus.FetchFault}, 32'd0);
        step();
        check_val("mis_fault", {31'd0, bus.FetchFault}, 32'd1);
        check_val("mis_valid", {31'd0, bus.IfIdValid}, 32'd0);
        check_val("mis_addr", bus.ImemAddr, 32'h6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
